// File: rtl/tx_lane_scheduler.sv
// Two-requester round-robin byte scheduler feeding an 8:1 serializer; bytes accepted at slot 0 appear 1 cycle later for 8 cycles.
// Backpressure: readies pulse only at the slot-0 boundary in RUN with enable high; otherwise requesters hold their valid and wait.
module tx_lane_scheduler #(
  parameter int unsigned TRAIN_BYTES = 4,
  parameter logic [7:0]  IDLE_CHAR   = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [7:0]  par_data_out,
  output logic        par_valid_out,
  output logic        lane_id_out,
  output logic        byte_strobe,
  output logic        sync_done,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    TRAIN    = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_BYTES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] train_cnt;
  logic [7:0] train_cnt_next;
  logic [2:0] slot;
  logic       boundary;
  logic       last_grant;
  logic       grant_sel;
  logic       accept_window;
  logic       xfer0;
  logic       xfer1;

  assign boundary = (slot == 3'd0);

  // Readies are gated by enable so a boundary that leaves RUN never accepts a byte.
  always_comb begin
    accept_window = boundary && (state == RUN) && enable;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1_valid;
    end
    req0_ready = accept_window && req0_valid && !grant_sel;
    req1_ready = accept_window && req1_valid && grant_sel;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
  end

  always_comb begin
    state_next     = state;
    train_cnt_next = train_cnt;
    case (state)
      DISABLED: begin
        if (enable) begin
          state_next     = TRAIN;
          train_cnt_next = 8'd0;
        end
      end
      TRAIN: begin
        if (!enable) begin
          state_next     = DISABLED;
          train_cnt_next = 8'd0;
        end else if (train_cnt == TRAIN_LAST) begin
          state_next     = RUN;
          train_cnt_next = 8'd0;
        end else begin
          train_cnt_next = train_cnt + 8'd1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = DISABLED;
        end
      end
      default: begin
        state_next     = DISABLED;
        train_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= DISABLED;
      train_cnt <= 8'd0;
    end else if (boundary) begin
      state     <= state_next;
      train_cnt <= train_cnt_next;
    end
  end

  // Slot and strobe run free; everything else only moves at the byte boundary.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      slot        <= 3'd7;
      byte_strobe <= 1'b0;
    end else begin
      slot        <= slot - 3'd1;
      byte_strobe <= boundary;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      par_data_out  <= IDLE_CHAR;
      par_valid_out <= 1'b0;
      lane_id_out   <= 1'b0;
      sync_done     <= 1'b0;
      cnt0          <= 16'd0;
      cnt1          <= 16'd0;
      last_grant    <= 1'b1;
    end else if (boundary) begin
      sync_done <= (state_next == RUN);
      if (xfer0) begin
        par_data_out  <= req0_data;
        par_valid_out <= 1'b1;
        lane_id_out   <= 1'b0;
        cnt0          <= cnt0 + 16'd1;
        last_grant    <= 1'b0;
      end else if (xfer1) begin
        par_data_out  <= req1_data;
        par_valid_out <= 1'b1;
        lane_id_out   <= 1'b1;
        cnt1          <= cnt1 + 16'd1;
        last_grant    <= 1'b1;
      end else begin
        par_data_out  <= IDLE_CHAR;
        par_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: a per-boundary vector table plus hand sequences for
// dropped valids, enable loss and retrain, counter wrap and mid-byte reset.
module tb_tx_lane_scheduler;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  req0_data;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req1_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  par_data_out;
  logic        par_valid_out;
  logic        lane_id_out;
  logic        byte_strobe;
  logic        sync_done;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;

  tx_lane_scheduler #(.TRAIN_BYTES(4), .IDLE_CHAR(8'hBC)) dut (
    .clk_32f(clk_32f), .reset(reset), .enable(enable),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .par_data_out(par_data_out), .par_valid_out(par_valid_out), .lane_id_out(lane_id_out),
    .byte_strobe(byte_strobe), .sync_done(sync_done), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference slot position, kept by the bench from reset and the clock alone.
  logic [2:0] tb_slot;
  always @(posedge clk_32f) begin
    if (reset) tb_slot <= 3'd7;
    else       tb_slot <= tb_slot - 3'd1;
  end

  typedef struct {
    logic        en;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        r0;
    logic        r1;
    logic [7:0]  dat;
    logic        pv;
    logic        lane;
    logic        sync;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic en, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1,
                              input logic r0, input logic r1, input logic [7:0] dat,
                              input logic pv, input logic lane, input logic sync,
                              input logic [15:0] c0, input logic [15:0] c1);
    vec_t v;
    v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.dat = dat; v.pv = pv; v.lane = lane; v.sync = sync;
    v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic goto_slot(input logic [2:0] s);
    while (tb_slot != s) @(negedge clk_32f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] prev_dat;

  initial begin
    reset = 1'b1; enable = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;

    //                en  v0  d0     v1  d1     r0  r1  dat    pv  ln  syn  c0     c1
    vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hBC, 0, 0, 0, 16'd0, 16'd0);
    vecs[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hBC, 0, 0, 0, 16'd0, 16'd0);
    vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hBC, 0, 0, 0, 16'd0, 16'd0);
    vecs[3]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hBC, 0, 0, 0, 16'd0, 16'd0);
    vecs[4]  = mk(1, 1, 8'h55, 0, 8'h00, 0, 0, 8'hBC, 0, 0, 1, 16'd0, 16'd0);
    vecs[5]  = mk(1, 1, 8'hA0, 1, 8'hB0, 1, 0, 8'hA0, 1, 0, 1, 16'd1, 16'd0);
    vecs[6]  = mk(1, 1, 8'hA1, 1, 8'hB1, 0, 1, 8'hB1, 1, 1, 1, 16'd1, 16'd1);
    vecs[7]  = mk(1, 1, 8'hA2, 1, 8'hB2, 1, 0, 8'hA2, 1, 0, 1, 16'd2, 16'd1);
    vecs[8]  = mk(1, 1, 8'hA3, 1, 8'hB3, 0, 1, 8'hB3, 1, 1, 1, 16'd2, 16'd2);
    vecs[9]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hBC, 0, 1, 1, 16'd2, 16'd2);
    vecs[10] = mk(1, 1, 8'h11, 0, 8'h00, 1, 0, 8'h11, 1, 0, 1, 16'd3, 16'd2);
    vecs[11] = mk(1, 1, 8'h22, 0, 8'h00, 1, 0, 8'h22, 1, 0, 1, 16'd4, 16'd2);
    vecs[12] = mk(1, 0, 8'h00, 1, 8'h33, 0, 1, 8'h33, 1, 1, 1, 16'd4, 16'd3);

    repeat (2) @(negedge clk_32f);
    reset = 1'b0;

    check("rst_data", par_data_out, 8'hBC);
    check("rst_pvalid", par_valid_out, 1'b0);
    check("rst_lane", lane_id_out, 1'b0);
    check("rst_strobe", byte_strobe, 1'b0);
    check("rst_sync", sync_done, 1'b0);
    check("rst_cnt0", cnt0, 16'd0);
    check("rst_cnt1", cnt1, 16'd0);
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    prev_dat = 8'hBC;

    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en;
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
      check($sformatf("v%0d_ready_offslot", i), {req0_ready, req1_ready}, 2'b00);
      goto_slot(3'd0);
      check($sformatf("v%0d_ready", i), {req0_ready, req1_ready}, {vecs[i].r0, vecs[i].r1});
      check($sformatf("v%0d_hold", i), par_data_out, prev_dat);
      @(negedge clk_32f);
      check($sformatf("v%0d_data", i), par_data_out, vecs[i].dat);
      check($sformatf("v%0d_pvalid", i), par_valid_out, vecs[i].pv);
      check($sformatf("v%0d_lane", i), lane_id_out, vecs[i].lane);
      check($sformatf("v%0d_sync", i), sync_done, vecs[i].sync);
      check($sformatf("v%0d_cnt0", i), cnt0, vecs[i].c0);
      check($sformatf("v%0d_cnt1", i), cnt1, vecs[i].c1);
      check($sformatf("v%0d_strobe", i), byte_strobe, 1'b1);
      prev_dat = vecs[i].dat;
    end

    // Valid withdrawn before the boundary is never granted.
    req0_valid = 1'b1; req0_data = 8'h44; req1_valid = 1'b0;
    goto_slot(3'd3);
    req0_valid = 1'b0;
    goto_slot(3'd0);
    check("drop_ready0", req0_ready, 1'b0);
    @(negedge clk_32f);
    check("drop_data", par_data_out, 8'hBC);
    check("drop_cnt0", cnt0, 16'd4);

    req1_valid = 1'b1; req1_data = 8'h55;
    goto_slot(3'd0);
    check("held_ready1", req1_ready, 1'b1);
    @(negedge clk_32f);
    check("held_data", par_data_out, 8'h55);
    check("held_cnt1", cnt1, 16'd4);
    req1_valid = 1'b0;

    // Enable loss mid-byte, then full retrain before grants resume.
    req0_valid = 1'b1; req0_data = 8'h66;
    goto_slot(3'd0);
    check("en_ready0", req0_ready, 1'b1);
    @(negedge clk_32f);
    check("en_data", par_data_out, 8'h66);
    goto_slot(3'd3);
    enable = 1'b0;
    goto_slot(3'd0);
    check("dis_ready0", req0_ready, 1'b0);
    check("dis_hold", par_data_out, 8'h66);
    @(negedge clk_32f);
    check("dis_data", par_data_out, 8'hBC);
    check("dis_pvalid", par_valid_out, 1'b0);
    check("dis_sync", sync_done, 1'b0);
    check("dis_cnt0", cnt0, 16'd5);
    enable = 1'b1; req0_data = 8'h77;
    for (int k = 0; k < 5; k++) begin
      goto_slot(3'd0);
      check($sformatf("retrain%0d_ready0", k), req0_ready, 1'b0);
      @(negedge clk_32f);
      check($sformatf("retrain%0d_sync", k), sync_done, (k == 4) ? 1'b1 : 1'b0);
      check($sformatf("retrain%0d_data", k), par_data_out, 8'hBC);
    end
    goto_slot(3'd0);
    check("resume_ready0", req0_ready, 1'b1);
    @(negedge clk_32f);
    check("resume_data", par_data_out, 8'h77);
    check("resume_cnt0", cnt0, 16'd6);
    req0_valid = 1'b0;

    // Counter wrap: preload cnt0 to all-ones, then one more transfer.
    force dut.cnt0 = 16'hFFFF;
    @(negedge clk_32f);
    release dut.cnt0;
    req0_valid = 1'b1; req0_data = 8'h88;
    goto_slot(3'd0);
    @(negedge clk_32f);
    check("wrap_cnt0", cnt0, 16'd0);
    check("wrap_cnt1", cnt1, 16'd4);
    check("wrap_data", par_data_out, 8'h88);
    check("wrap_pvalid", par_valid_out, 1'b1);
    check("wrap_sync", sync_done, 1'b1);
    req0_valid = 1'b0;

    // Reset in the middle of a data byte.
    goto_slot(3'd4);
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
    check("mid_rst_data", par_data_out, 8'hBC);
    check("mid_rst_pvalid", par_valid_out, 1'b0);
    check("mid_rst_lane", lane_id_out, 1'b0);
    check("mid_rst_cnt0", cnt0, 16'd0);
    check("mid_rst_cnt1", cnt1, 16'd0);
    check("mid_rst_sync", sync_done, 1'b0);
    check("mid_rst_strobe", byte_strobe, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_32f);
      check($sformatf("strobe_c%0d", k), byte_strobe, (tb_slot == 3'd7) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_lane_scheduler.md
TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

Interface
REQ-001 Parameter TRAIN_BYTES, default 4, SHALL set the number of idle bytes sent in TRAIN before RUN (range 1..255).
REQ-002 Parameter IDLE_CHAR, default 8'hBC, SHALL be the comma/idle byte driven whenever no data byte is scheduled.
REQ-003 clk_32f  input  1  bit clock; reset, synchronous, active-high; clock clk_32f.
REQ-004 reset  input  1  synchronous active-high reset, sampled on posedge clk_32f.
REQ-005 enable  input  1  link enable; level-sensitive.
REQ-006 req0_data / req1_data  input  8 each  byte offered by requester 0 / 1.
REQ-007 req0_valid / req1_valid  input  1 each  requester has a byte.
REQ-008 req0_ready / req1_ready  output  1 each  combinational grant; transfer occurs when valid and ready are both high on a clock edge.
REQ-009 par_data_out  output  8  registered byte presented to the serializer, held for 8 cycles.
REQ-010 par_valid_out  output  1  high when par_data_out carries requester data, low for IDLE_CHAR.
REQ-011 lane_id_out  output  1  requester index of the current par_data_out byte.
REQ-012 byte_strobe  output  1  registered one-cycle pulse on the first bit cycle of each new byte.
REQ-013 sync_done  output  1  high while in RUN.
REQ-014 cnt0 / cnt1  output  16 each  bytes accepted from requester 0 / 1.

Function
REQ-015 A 3-bit slot counter SHALL decrement 7->0 every clk_32f and wrap 0->7, free-running in every state; slot==0 is the byte boundary.
REQ-016 All state and output register updates other than slot and byte_strobe SHALL occur only on byte-boundary edges (slot==0).
REQ-017 States SHALL be DISABLED, TRAIN and RUN, evaluated at the boundary: DISABLED->TRAIN if enable; TRAIN->RUN after TRAIN_BYTES boundaries spent in TRAIN; TRAIN or RUN->DISABLED if !enable, with priority over other transitions.
REQ-018 In DISABLED and TRAIN, each boundary SHALL load par_data_out=IDLE_CHAR and par_valid_out=0, and both readies SHALL stay 0.
REQ-019 In RUN at slot==0, reqN_ready SHALL be 1 only for the granted requester; readies SHALL be 0 at all other slots and in all other states.
REQ-020 Grant is round-robin: if only one requester is valid, grant it; if both are valid, grant the one not granted last; the last-grant pointer updates only on a transfer and resets to 1, so requester 0 wins the first tie.
REQ-021 On a transfer edge: par_data_out=reqN_data, par_valid_out=1, lane_id_out=N, cntN+1 (wraps at 16'hFFFF->0).
REQ-022 At a RUN boundary with no valid requester: par_data_out=IDLE_CHAR, par_valid_out=0, lane_id_out unchanged.
REQ-023 byte_strobe SHALL be 1 exactly in cycles where slot==7, excluding the first cycle after reset.
REQ-024 Latency: a byte accepted at boundary edge k SHALL appear on par_data_out during cycles k+1..k+8.
REQ-025 sync_done SHALL be registered: 1 from the edge entering RUN, 0 from the edge leaving RUN.
REQ-026 A valid that drops before the boundary SHALL not be granted; a held valid SHALL wait for the next boundary.

Reset
REQ-027 Reset SHALL force state=DISABLED, slot=7, par_data_out=IDLE_CHAR, par_valid_out=0, lane_id_out=0, byte_strobe=0, sync_done=0, cnt0=cnt1=0, last grant=1, train counter=0, irrespective of slot position.
REQ-028 Reset mid-byte SHALL discard the in-flight byte; the byte is not re-offered and cntN keeps no record of it.

Verification
REQ-029 Reset with enable=1, no valids -> idle 0xBC on every boundary; sync_done rises at the boundary that completes 4 TRAIN bytes after leaving DISABLED (TRAIN_BYTES=4); both readies stay 0 until then.
REQ-030 RUN with req0 only valid, data 0x11,0x22 -> req0_ready high at consecutive slot==0 cycles; par_data_out 0x11 then 0x22, 8 cycles each; par_valid_out=1; cnt0=2.
REQ-031 Both valid continuously, req0 0xA0.., req1 0xB0.. -> lane_id_out alternates 0,1,0,1, starting with 0; cnt0==cnt1 after an even number of grants.
REQ-032 enable dropped at slot 3 in RUN -> current byte completes; next boundary -> IDLE_CHAR, sync_done=0; re-enable -> full TRAIN of 4 bytes before grants resume.
REQ-033 reset asserted at slot 4 during a data byte -> next cycle: par_data_out=0xBC, par_valid_out=0, slot=7, counters 0.
REQ-034 cnt0 preloaded to 16'hFFFF via 65535 transfers, one more transfer -> cnt0=0, no other effect.
